// File: rtl/stat_resp_misr.sv
// stat_resp_misr - response compactor for the Stat_* combinational benchmarks.
//
// Folds one WIDTH-bit response vector per accepted handshake into a multiple-
// input signature register over a programmed number of patterns. At the end of
// the run, the block compares the signature against a golden value and reports
// pass/fail.
//
// Optional feature: define STAT_MISR_XMASK_EN to add the resp_mask input.
// Bits set in resp_mask are forced to 0 before compaction.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   start         begin a run (honoured in IDLE and DONE only)
//   num_patterns  patterns to compact, sampled on an accepted start
//   golden        expected signature, sampled on an accepted start
//   resp_valid    response vector valid
//   resp_data     benchmark output vector (LSB = first output)
//   resp_mask     (STAT_MISR_XMASK_EN only) per-bit mask, 1 = ignore bit
//   resp_ready    block accepts a vector this cycle (state == RUN)
//   busy          high in RUN
//   done          high in DONE
//   pass          signature == golden, meaningful only while done
//   signature     current MISR state
//   count         vectors accepted in the current run
module stat_resp_misr #(
    parameter int unsigned     WIDTH = 18,
    parameter int unsigned     CNT_W = 16,
    parameter logic [WIDTH-1:0] POLY = 18'h00801,
    parameter logic [WIDTH-1:0] SEED = 18'h00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
`ifdef STAT_MISR_XMASK_EN
    input  logic [WIDTH-1:0] resp_mask,
`endif
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] np_q;
    logic [WIDTH-1:0] golden_q;
    logic [WIDTH-1:0] data_eff;
    logic [WIDTH-1:0] sig_next;
    logic [CNT_W-1:0] count_next;
    logic             accept;

    assign resp_ready = (state == ST_RUN);
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);
    assign accept     = resp_valid && resp_ready;

`ifdef STAT_MISR_XMASK_EN
    assign data_eff = resp_data & ~resp_mask;
`else
    assign data_eff = resp_data;
`endif

    // Shift left one position. When the bit shifted out of the MSB is 1,
    // XOR POLY into the result as feedback. Then XOR in the new response.
    always_comb begin
        sig_next   = '0;
        count_next = '0;
        sig_next   = {signature[WIDTH-2:0], 1'b0}
                     ^ (signature[WIDTH-1] ? POLY : '0)
                     ^ data_eff;
        count_next = count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            signature <= SEED;
            count     <= '0;
            pass      <= 1'b0;
            np_q      <= '0;
            golden_q  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        signature <= SEED;
                        count     <= '0;
                        if (num_patterns != '0) begin
                            np_q     <= num_patterns;
                            golden_q <= golden;
                            pass     <= 1'b0;
                            state    <= ST_RUN;
                        end else begin
                            // Empty run: the result is just the seed checked
                            // against the golden value on the port.
                            pass  <= (SEED == golden);
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        signature <= sig_next;
                        count     <= count_next;
                        if (count_next == np_q) begin
                            pass  <= (sig_next == golden_q);
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stat_resp_misr.sv
// tb_stat_resp_misr - directed bench for stat_resp_misr.
// The bench drives inputs 1 ns after each rising edge.
// It samples outputs at that same point, after the registers have settled.
module tb_stat_resp_misr;

    localparam int unsigned WIDTH = 18;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_patterns;
    logic [WIDTH-1:0] golden;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
`ifdef STAT_MISR_XMASK_EN
    logic [WIDTH-1:0] resp_mask;
`endif
    logic             resp_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    stat_resp_misr #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .POLY (18'h00801),
        .SEED (18'h00000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_patterns(num_patterns),
        .golden      (golden),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
`ifdef STAT_MISR_XMASK_EN
        .resp_mask   (resp_mask),
`endif
        .resp_ready  (resp_ready),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [CNT_W-1:0] np, input logic [WIDTH-1:0] g);
        start        = 1'b1;
        num_patterns = np;
        golden       = g;
        tick();
        start        = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        resp_valid = 1'b1;
        resp_data  = d;
        tick();
        resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_patterns = '0; golden = '0;
        resp_valid = 1'b0; resp_data = '0;
`ifdef STAT_MISR_XMASK_EN
        resp_mask = '0;
`endif
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset and idle state
        chk("rst_sig",   32'(signature),  32'h0);
        chk("rst_count", 32'(count),      32'h0);
        chk("rst_ready", 32'(resp_ready), 32'h0);
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_done",  32'(done),       32'h0);
        chk("rst_pass",  32'(pass),       32'h0);

        // Single pattern
        do_start(16'd1, 18'h00001);
        chk("p1_busy",  32'(busy),       32'h1);
        chk("p1_ready", 32'(resp_ready), 32'h1);
        send(18'h00001);
        chk("p1_sig",   32'(signature),  32'h00001);
        chk("p1_count", 32'(count),      32'h1);
        chk("p1_done",  32'(done),       32'h1);
        chk("p1_pass",  32'(pass),       32'h1);
        chk("p1_ready", 32'(resp_ready), 32'h0);

        // Two patterns: the MSB feeds back through POLY
        do_start(16'd2, 18'h00801);
        send(18'h20000);
        chk("p2_sig1",  32'(signature), 32'h20000);
        chk("p2_done1", 32'(done),      32'h0);
        send(18'h00000);
        chk("p2_sig2",  32'(signature), 32'h00801);
        chk("p2_done",  32'(done),      32'h1);
        chk("p2_pass",  32'(pass),      32'h1);

        do_start(16'd2, 18'h00800);
        chk("p2b_pass_clr", 32'(pass), 32'h0);
        send(18'h20000);
        send(18'h00000);
        chk("p2b_sig",  32'(signature), 32'h00801);
        chk("p2b_done", 32'(done),      32'h1);
        chk("p2b_pass", 32'(pass),      32'h0);

        // Three patterns with valid gaps:
        // signature goes 3 -> 6^10 = 16 -> 2C^20000 = 2002C
        do_start(16'd3, 18'h2002C);
        send(18'h00003);
        chk("p3_sig0", 32'(signature), 32'h00003);
        repeat (4) tick();
        chk("p3_gap_sig",   32'(signature), 32'h00003);
        chk("p3_gap_count", 32'(count),     32'h1);
        chk("p3_gap_busy",  32'(busy),      32'h1);
        send(18'h00010);
        chk("p3_sig1",  32'(signature), 32'h00016);
        chk("p3_cnt1",  32'(count),     32'h2);
        chk("p3_done1", 32'(done),      32'h0);
        send(18'h20000);
        chk("p3_sig2",  32'(signature), 32'h2002C);
        chk("p3_cnt2",  32'(count),     32'h3);
        chk("p3_done",  32'(done),      32'h1);
        chk("p3_pass",  32'(pass),      32'h1);

        // In DONE, resp_valid is ignored
        send(18'h3FFFF);
        chk("dn_hold_sig",   32'(signature), 32'h2002C);
        chk("dn_hold_count", 32'(count),     32'h3);
        chk("dn_hold_pass",  32'(pass),      32'h1);

        // A start during RUN is ignored; a reset mid-run aborts the run
        do_start(16'd5, 18'h00000);
        send(18'h00001);
        send(18'h00001);
        chk("ab_sig",   32'(signature), 32'h00003);
        do_start(16'd1, 18'h00000);
        chk("ab_start_ign_busy",  32'(busy),  32'h1);
        chk("ab_start_ign_count", 32'(count), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_rst_sig",   32'(signature), 32'h0);
        chk("ab_rst_count", 32'(count),     32'h0);
        chk("ab_rst_busy",  32'(busy),      32'h0);
        chk("ab_rst_done",  32'(done),      32'h0);

        // Zero-pattern run goes straight to DONE
        do_start(16'd0, 18'h00000);
        chk("z_done",  32'(done),  32'h1);
        chk("z_pass",  32'(pass),  32'h1);
        chk("z_count", 32'(count), 32'h0);
        do_start(16'd0, 18'h00005);
        chk("z2_done", 32'(done), 32'h1);
        chk("z2_pass", 32'(pass), 32'h0);

`ifdef STAT_MISR_XMASK_EN
        // Masked bits contribute nothing to the signature
        do_start(16'd1, 18'h00000);
        resp_mask = 18'h3FFFF;
        send(18'h1ABCD);
        chk("xm_full_sig",  32'(signature), 32'h0);
        chk("xm_full_pass", 32'(pass),      32'h1);
        do_start(16'd1, 18'h1ABCD);
        resp_mask = 18'h00000;
        send(18'h1ABCD);
        chk("xm_none_sig",  32'(signature), 32'h1ABCD);
        chk("xm_none_pass", 32'(pass),      32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
